ssd_scan_driver: RTL
====================

// Module: ssd_scan_driver
// PURPOSE
//  Multiplexed N-digit BCD seven-segment driver: latches packed BCD, DP and per-digit blank masks, scans one digit per slot.
//  Decodes each digit to active-low segments {a,b,c,d,e,f,g,dp} (bit7=a .. bit0=dp); undriven/invalid codes give 8'hFF.
//  Sits between the game/score logic and the board's shared segment bus plus per-digit active-low anodes.
// PARAMETERS
//  DIGITS    4       number of digits scanned (1..8)
//  SLOT_CYC  100000  clk cycles per digit slot (>= GHOST_CYC+2)
//  GHOST_CYC 16      cycles at slot start with all anodes off (anti-ghosting)
// PORTS
//  clk        in   1          system clock, all logic rising-edge
//  rst        in   1          asynchronous, active-high reset
//  bcd_in     in   4*DIGITS   packed BCD, digit 0 (rightmost) in [3:0]
//  dp_in      in   DIGITS     decimal point request per digit, 1 = lit
//  blank_in   in   DIGITS     per-digit blank, 1 = digit dark
//  load       in   1          1-cycle strobe: capture bcd_in/dp_in/blank_in
//  an         out  DIGITS     anode enables, active-low, at most one low
//  segs       out  8          segment drive, active-low
//  frame_done out  1          1-cycle pulse when last digit slot ends
// BEHAVIOUR
//  Reset: an=all 1s, segs=8'hFF, frame_done=0, slot counter=0, digit index=0,
//   pending/shown BCD=0, DP=0, blank=all 1s (display dark until first commit), pend_valid=0.
//  load: pending <= inputs on the same edge; pend_valid <= 1; repeated loads overwrite (last wins).
//  Commit: when slot counter wraps on digit DIGITS-1, shown <= pending if pend_valid, pend_valid <= 0;
//   load on that same edge goes to pending and commits at next frame end (no tearing mid-frame).
//  Slot counter 0..SLOT_CYC-1; at SLOT_CYC-1 -> 0 and digit index increments, DIGITS-1 wraps to 0.
//  frame_done=1 for exactly the cycle after index wraps to 0 (aligned with commit becoming visible).
//  Outputs registered: an/segs reflect index/counter of previous cycle (1-cycle latency).
//  Counter < GHOST_CYC: an=all 1s, segs=8'hFF. Else an[index]=0, segs=decode(shown digit) with dp bit cleared if dp set.
//  Blanked digit: anode still sequenced, segs=8'hFF (DP suppressed too). BCD 10..15: segs=8'hFF, DP still honoured.
//  Reset mid-scan: all state returns to reset values asynchronously; resumes at digit 0, dark until next commit.
// CONFIGURATION
//  SSD_LZ_SUPPRESS_EN defined: leading zeros (from digit DIGITS-1 down, stopping at first non-zero) are
//   blanked as if blank_in set; digit 0 never suppressed; DP on a suppressed digit still lit. Computed on shown regs.
//  Undefined: zeros displayed as '0' on every non-blanked digit.
// STRUCTURE
//  Package ssd_pkg: SEG_0..SEG_9 and SEG_OFF (8'hFF) constants, seg_t typedef (logic [7:0]).
//  Sub-module ssd_decode: combinational 4-bit BCD -> seg_t, dp bit forced 1; one instance, muxed input.
//  Top holds prescaler, digit index, pending/shown registers, LZ logic, output registers.
// TESTING (bench uses SLOT_CYC=20, GHOST_CYC=2, DIGITS=4)
//  Reset then idle 2 frames -> an=4'b1111 whenever sampled, segs=8'hFF, frame_done every 80 cycles.
//  load bcd=16'h1234, dp=0, blank=0 -> after next frame_done: digit0 an=4'b1110 segs=8'b1001_1001 ('4'), digit3 an=4'b0111 segs=8'b1001_1111 ('1').
//  Two loads within one frame (16'h1111 then 16'h5678) -> no partial frame; next frame shows 5678 only.
//  Digit 2 loaded with 4'hC, dp[2]=1 -> segs=8'b1111_1110 in slot 2; blank[1]=1 -> segs=8'hFF in slot 1.
//  Ghost window: first 2 cycles of each slot an=4'b1111; never two anodes low; check every cycle.
//  SSD_LZ_SUPPRESS_EN with 16'h0070 -> digits 3,2 dark, '7' and '0' shown; 16'h0000 -> only digit0 '0'; without macro 0070 shows 4 digits.
//  Assert rst mid-slot 2 -> same cycle an=4'b1111, segs=8'hFF; after release dark until a new load commits.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared seven-segment types and active-low glyph constants {a,b,c,d,e,f,g,dp}.
package ssd_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0   = 8'b0000_0011;
    localparam seg_t SEG_1   = 8'b1001_1111;
    localparam seg_t SEG_2   = 8'b0010_0101;
    localparam seg_t SEG_3   = 8'b0000_1101;
    localparam seg_t SEG_4   = 8'b1001_1001;
    localparam seg_t SEG_5   = 8'b0100_1001;
    localparam seg_t SEG_6   = 8'b0100_0001;
    localparam seg_t SEG_7   = 8'b0001_1111;
    localparam seg_t SEG_8   = 8'b0000_0001;
    localparam seg_t SEG_9   = 8'b0000_1001;
    localparam seg_t SEG_OFF = 8'hFF;

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bus between the score logic (master) and the scanned display driver (slave).
interface ssd_scan_driver_if
    import ssd_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic [DIGITS-1:0]   an;
    seg_t                segs;
    logic                frame_done;

    modport master (
        output bcd_in, dp_in, blank_in, load,
        input  an, segs, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, blank_in, load,
        output an, segs, frame_done
    );
endinterface

// File: rtl/ssd_decode.sv
// BCD to active-low segment decoder; dp bit always off, codes 10..15 dark.
module ssd_decode
    import ssd_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with frame-aligned commit of new values.
// Optional macro SSD_LZ_SUPPRESS_EN blanks leading zeros of the shown value.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SLOT_CYC  = 100000,
    parameter int GHOST_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    ssd_scan_driver_if.slave bus
);
    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] pend_bcd, shown_bcd;
    logic [DIGITS-1:0]   pend_dp, pend_blank, shown_dp, shown_blank;
    logic                pend_valid;
    logic                lit;
    logic [DIGITS-1:0]   an_r;
    seg_t                segs_r;
    logic                frame_done_r;

    logic                slot_end, frame_end, dark;
    logic [DIGITS-1:0]   lz, an_next;
    logic [3:0]          dig_bcd;
    logic                dig_dp, dig_blank, dig_lz;
    seg_t                dig_seg, seg_next;

`ifdef SSD_LZ_SUPPRESS_EN
    logic zero_run;

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (shown_bcd[i*4 +: 4] == 4'd0);
            lz[i]    = zero_run;
        end
    end
`else
    assign lz = '0;
`endif

    // Anodes stay off until something has been committed, even though the reset
    // blank mask would already darken the segments.
    always_comb begin
        slot_end  = (cnt == SLOT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        dark      = (cnt < GHOST_END) || !lit;
        dig_bcd   = '0;
        dig_dp    = 1'b0;
        dig_blank = 1'b1;
        dig_lz    = 1'b0;
        an_next   = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                dig_bcd    = shown_bcd[i*4 +: 4];
                dig_dp     = shown_dp[i];
                dig_blank  = shown_blank[i];
                dig_lz     = lz[i];
                an_next[i] = dark;
            end
        end
    end

    ssd_decode u_decode (
        .bcd (dig_bcd),
        .seg (dig_seg)
    );

    always_comb begin
        if (dark || dig_blank)
            seg_next = SEG_OFF;
        else if (dig_lz)
            seg_next = SEG_OFF & {7'h7F, ~dig_dp};
        else
            seg_next = dig_seg & {7'h7F, ~dig_dp};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            pend_bcd     <= '0;
            pend_dp      <= '0;
            pend_blank   <= '1;
            pend_valid   <= 1'b0;
            shown_bcd    <= '0;
            shown_dp     <= '0;
            shown_blank  <= '1;
            lit          <= 1'b0;
            an_r         <= '1;
            segs_r       <= SEG_OFF;
            frame_done_r <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            frame_done_r <= frame_end;

            if (frame_end && pend_valid) begin
                shown_bcd   <= pend_bcd;
                shown_dp    <= pend_dp;
                shown_blank <= pend_blank;
                lit         <= 1'b1;
            end

            // A load on the commit edge lands in pending and waits a full frame.
            if (bus.load) begin
                pend_bcd   <= bus.bcd_in;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end

            an_r   <= an_next;
            segs_r <= seg_next;
        end
    end

    assign bus.an         = an_r;
    assign bus.segs       = segs_r;
    assign bus.frame_done = frame_done_r;
endmodule
